// File: rtl/wb_stage_pkg.sv
// Shared write-back definitions: result-select codes, load funct3 codes
// and the offset-width helper used by the stage and its load extractor.
package wb_stage_pkg;

  // Source selection for the register-file write data.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_RAM = 2'd1,
    WB_PC4 = 2'd2,
    WB_EXT = 2'd3
  } wb_sel_e;

  // Load funct3 encodings; LD and LWU exist only on a 64-bit datapath.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } ld_op_e;

  // Number of byte-offset address bits within one datapath word.
  function automatic int off_w(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load data extraction: aligns the addressed field of the memory read word
// to bit 0, sign/zero-extends it, and flags misaligned accesses.
module load_ext
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [off_w(XLEN)-1:0] addr_lo,
  input  logic [XLEN-1:0]        rdo,
  input  logic [2:0]             ld_op,
  output logic [XLEN-1:0]        data,
  output logic                   misaligned
);

  localparam int OFF_W = off_w(XLEN);

  logic [XLEN-1:0] shifted;

  assign shifted = rdo >> {addr_lo, 3'b000};

  // Extend the aligned field by load type; unknown types read as zero, aligned.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    data       = '0;
    misaligned = 1'b0;
    case (ld_op)
      LB:  data = XLEN'($signed(shifted[7:0]));
      LBU: data = XLEN'(shifted[7:0]);
      LH: begin
        data       = XLEN'($signed(shifted[15:0]));
        misaligned = addr_lo[0];
      end
      LHU: begin
        data       = XLEN'(shifted[15:0]);
        misaligned = addr_lo[0];
      end
      LW: begin
        data       = XLEN'($signed(shifted[31:0]));
        misaligned = (addr_lo[1:0] != 2'b00);
      end
      LWU: begin
        if (XLEN == 64) begin
          data       = XLEN'(shifted[31:0]);
          misaligned = (addr_lo[1:0] != 2'b00);
        end
      end
      LD: begin
        if (XLEN == 64) begin
          data       = shifted;
          misaligned = (addr_lo != OFF_W'(0));
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: one-cycle WB register with stall/flush, result
// selection, register-file write port, EX forwarding and retire counter.
// XLEN must be 32 or 64.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic             in_ready,
  input  logic             in_rf_we,
  input  logic [RA_W-1:0]  in_rd,
  input  logic [1:0]       in_rf_wsel,
  input  logic [2:0]       in_ld_op,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [XLEN-1:0]  in_alu_c,
  input  logic [XLEN-1:0]  in_dram_rdo,
  input  logic [XLEN-1:0]  in_imm_ext,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [RA_W-1:0]  fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             misalign,
  output logic [CNT_W-1:0] instret
);

  localparam int OFF_W = off_w(XLEN);

  logic             valid_q, rf_we_q;
  logic [RA_W-1:0]  rd_q;
  logic [1:0]       rf_wsel_q;
  logic [2:0]       ld_op_q;
  logic [XLEN-1:0]  pc4_q, alu_c_q, dram_rdo_q, imm_ext_q;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [XLEN-1:0]  ld_data;
  logic             ld_misaligned;
  logic             misaligned_load;
  logic             retire;

  // WB register: reset clears all, flush kills valid, stall holds, else capture.
  always_ff @(posedge cpu_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (cpu_rst) begin
      valid_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rd_q       <= '0;
      rf_wsel_q  <= '0;
      ld_op_q    <= '0;
      pc4_q      <= '0;
      alu_c_q    <= '0;
      dram_rdo_q <= '0;
      imm_ext_q  <= '0;
      instret_q  <= '0;
    end else begin
      instret_q <= instret_d;
      if (flush) begin
        valid_q <= 1'b0;
      end else if (!stall) begin
        valid_q    <= in_valid;
        rf_we_q    <= in_rf_we;
        rd_q       <= in_rd;
        rf_wsel_q  <= in_rf_wsel;
        ld_op_q    <= in_ld_op;
        pc4_q      <= in_pc4;
        alu_c_q    <= in_alu_c;
        dram_rdo_q <= in_dram_rdo;
        imm_ext_q  <= in_imm_ext;
      end
    end
  end

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .addr_lo    (alu_c_q[OFF_W-1:0]),
    .rdo        (dram_rdo_q),
    .ld_op      (ld_op_q),
    .data       (ld_data),
    .misaligned (ld_misaligned)
  );

  // Misalignment only matters when the result actually comes from memory.
  assign misaligned_load = (rf_wsel_q == WB_RAM) && ld_misaligned;
  assign retire          = valid_q && !stall;

  // Result select; an unknown select code produces zero.
  always_comb begin
    rf_wdata = '0;
    case (rf_wsel_q)
      WB_ALU:  rf_wdata = alu_c_q;
      WB_RAM:  rf_wdata = ld_data;
      WB_PC4:  rf_wdata = pc4_q;
      WB_EXT:  rf_wdata = imm_ext_q;
      default: rf_wdata = '0;
    endcase
  end

  // Count each aligned retire; a misaligned load leaves the counter alone.
  always_comb begin
    instret_d = instret_q;
    if (retire && !misaligned_load) instret_d = instret_q + CNT_W'(1);
  end

  // Forwarding ignores stall; the actual write waits for the stall to lift.
  assign fwd_valid = !cpu_rst && valid_q && rf_we_q && (rd_q != '0) && !misaligned_load;
  assign rf_we     = fwd_valid && !stall;
  assign misalign  = !cpu_rst && retire && misaligned_load;
  assign in_ready  = !stall;
  assign rf_waddr  = rd_q;
  assign fwd_rd    = rd_q;
  assign fwd_data  = rf_wdata;
  assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (XLEN=32, RA_W=5, CNT_W=64).
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 64;

  logic             cpu_clk = 1'b0;
  logic             cpu_rst;
  logic             in_valid, stall, flush, in_ready;
  logic             in_rf_we;
  logic [RA_W-1:0]  in_rd;
  logic [1:0]       in_rf_wsel;
  logic [2:0]       in_ld_op;
  logic [XLEN-1:0]  in_pc4, in_alu_c, in_dram_rdo, in_imm_ext;
  logic             rf_we;
  logic [RA_W-1:0]  rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             fwd_valid;
  logic [RA_W-1:0]  fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic             misalign;
  logic [CNT_W-1:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .in_valid    (in_valid),
    .stall       (stall),
    .flush       (flush),
    .in_ready    (in_ready),
    .in_rf_we    (in_rf_we),
    .in_rd       (in_rd),
    .in_rf_wsel  (in_rf_wsel),
    .in_ld_op    (in_ld_op),
    .in_pc4      (in_pc4),
    .in_alu_c    (in_alu_c),
    .in_dram_rdo (in_dram_rdo),
    .in_imm_ext  (in_imm_ext),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .misalign    (misalign),
    .instret     (instret)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic present(input logic v, input logic we, input logic [RA_W-1:0] rd,
                         input logic [1:0] sel, input logic [2:0] op,
                         input logic [XLEN-1:0] pc4, input logic [XLEN-1:0] alu,
                         input logic [XLEN-1:0] rdo, input logic [XLEN-1:0] imm);
    in_valid    = v;
    in_rf_we    = we;
    in_rd       = rd;
    in_rf_wsel  = sel;
    in_ld_op    = op;
    in_pc4      = pc4;
    in_alu_c    = alu;
    in_dram_rdo = rdo;
    in_imm_ext  = imm;
  endtask

  task automatic idle();
    present(1'b0, 1'b0, '0, WB_ALU, LB, '0, '0, '0, '0);
  endtask

  initial begin
    cpu_rst = 1'b1;
    stall   = 1'b0;
    flush   = 1'b0;
    idle();
    tick();
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    check("rst_misalign", 64'(misalign), 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    stall = 1'b1;
    #1;
    check("rst_ready_stall", 64'(in_ready), 64'd0);
    stall   = 1'b0;
    cpu_rst = 1'b0;

    // LW aligned
    present(1'b1, 1'b1, 5'd5, WB_RAM, LW, '0, 32'h1000, 32'hDEADBEEF, '0);
    tick();
    // LB at byte 3, LBU queued behind it
    present(1'b1, 1'b1, 5'd6, WB_RAM, LB, '0, 32'h1003, 32'h80FF_0000, '0);
    check("lw_rf_we", 64'(rf_we), 64'd1);
    check("lw_waddr", 64'(rf_waddr), 64'd5);
    check("lw_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    check("lw_instret_pre", instret, 64'd0);
    tick();
    present(1'b1, 1'b1, 5'd6, WB_RAM, LBU, '0, 32'h1003, 32'h80FF_0000, '0);
    check("lw_instret", instret, 64'd1);
    check("lb_wdata", 64'(rf_wdata), 64'hFFFFFF80);
    check("lb_rf_we", 64'(rf_we), 64'd1);
    tick();
    // LH at odd address
    present(1'b1, 1'b1, 5'd7, WB_RAM, LH, '0, 32'h1001, 32'h1234_5678, '0);
    check("lbu_wdata", 64'(rf_wdata), 64'h00000080);
    check("lb_instret", instret, 64'd2);
    tick();
    idle();
    check("lh_misalign", 64'(misalign), 64'd1);
    check("lh_rf_we", 64'(rf_we), 64'd0);
    check("lh_fwd_valid", 64'(fwd_valid), 64'd0);
    check("lbu_instret", instret, 64'd3);
    tick();
    check("lh_misalign_gone", 64'(misalign), 64'd0);
    check("lh_instret", instret, 64'd3);

    // ALU op held by a 3-cycle stall
    present(1'b1, 1'b1, 5'd3, WB_ALU, LB, '0, 32'd7, '0, '0);
    tick();
    idle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_rf_we", 64'(rf_we), 64'd0);
      check("stall_fwd_valid", 64'(fwd_valid), 64'd1);
      check("stall_fwd_data", 64'(fwd_data), 64'd7);
      check("stall_instret", instret, 64'd3);
      if (i < 2) tick();
    end
    stall = 1'b0;
    #1;
    check("release_rf_we", 64'(rf_we), 64'd1);
    check("release_waddr", 64'(rf_waddr), 64'd3);
    check("release_wdata", 64'(rf_wdata), 64'd7);
    tick();
    check("release_instret", instret, 64'd4);
    check("release_once", 64'(rf_we), 64'd0);

    // Flush together with stall
    present(1'b1, 1'b1, 5'd9, WB_ALU, LB, '0, 32'h55, '0, '0);
    tick();
    idle();
    stall = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_pre_fwd", 64'(fwd_valid), 64'd1);
    tick();
    stall = 1'b0;
    flush = 1'b0;
    #1;
    check("flush_fwd_valid", 64'(fwd_valid), 64'd0);
    check("flush_rf_we", 64'(rf_we), 64'd0);
    tick();
    check("flush_instret", instret, 64'd4);

    // Immediate select, then undefined load type on a 32-bit datapath
    present(1'b1, 1'b1, 5'd10, WB_EXT, LB, '0, 32'h1, '0, 32'hABCD_0000);
    tick();
    present(1'b1, 1'b1, 5'd8, WB_RAM, LD, '0, 32'h1003, 32'hFFFF_FFFF, '0);
    check("ext_wdata", 64'(rf_wdata), 64'hABCD_0000);
    tick();
    idle();
    check("undef_ld_wdata", 64'(rf_wdata), 64'd0);
    check("undef_ld_misalign", 64'(misalign), 64'd0);
    check("undef_ld_rf_we", 64'(rf_we), 64'd1);
    tick();
    check("undef_ld_instret", instret, 64'd6);

    // JAL to x0
    present(1'b1, 1'b1, 5'd0, WB_PC4, LB, 32'h104, '0, '0, '0);
    tick();
    idle();
    check("jal_rf_we", 64'(rf_we), 64'd0);
    check("jal_fwd_valid", 64'(fwd_valid), 64'd0);
    tick();
    check("jal_instret", instret, 64'd7);
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    #1;
    check("rst_pulse_instret", instret, 64'd0);

    // Reset while an instruction is held
    present(1'b1, 1'b1, 5'd4, WB_ALU, LB, '0, 32'h1, '0, '0);
    tick();
    idle();
    stall = 1'b1;
    tick();
    cpu_rst = 1'b1;
    stall   = 1'b0;
    #1;
    check("rst_held_rf_we", 64'(rf_we), 64'd0);
    check("rst_held_fwd_valid", 64'(fwd_valid), 64'd0);
    tick();
    cpu_rst = 1'b0;
    #1;
    check("rst_held_valid_gone", 64'(fwd_valid), 64'd0);
    tick();
    check("rst_held_instret", instret, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
